ast_dma_sequencer: RTL and testbench
====================================

Name: ast_dma_sequencer

Overview:
- Descriptor-driven controller for the register-programmed AST DMA engine.
- Accepts transfer descriptors (cols, rows, stride, set, source address) over a valid/ready interface into a small FIFO.
- For each descriptor, programs the DMA register file through its write/select/data port, starts it, and waits for completion.
- Reports per-transfer completion and error status; the host never touches the DMA register file directly.

Parameters:
DATAWIDTH, 8, width of DMA data/address/dimension fields
DEPTH, 4, descriptor FIFO entries (power of two, >=2)
START_TIMEOUT, 15, max cycles from start write to dma_busy rising

Ports:
clk  in  1  clock
rst  in  1  reset; one clock, reset is synchronous and active-low
cmd_valid  in  1  descriptor valid
cmd_ready  out  1  FIFO can accept a descriptor
cmd_cols  in  DATAWIDTH  column count (DMA reg 0)
cmd_rows  in  DATAWIDTH  row count (DMA reg 1)
cmd_stride  in  DATAWIDTH  row stride, 0 = contiguous (DMA reg 6)
cmd_set  in  2  target: A=0, B=1, X=2 (read/pop), W=3 (DMA reg 2)
cmd_src  in  DATAWIDTH  start address (DMA reg 4)
dma_write  out  1  DMA register write strobe
dma_select  out  3  DMA register index
dma_data  out  DATAWIDTH  DMA register write data
dma_busy  in  1  DMA busy (high in WAIT/TRANSFER/FINISH)
seq_busy  out  1  high whenever state != IDLE or FIFO non-empty
done  out  1  one-cycle pulse per completed transfer
done_count  out  DATAWIDTH  completed transfers, wraps modulo 2^DATAWIDTH
err_zero  out  1  sticky: a descriptor with cols==0 or rows==0 was dropped
err_timeout  out  1  sticky: dma_busy failed to rise within START_TIMEOUT

Behaviour:
- Reset (rst==0 at posedge): FIFO emptied, state IDLE, dma_write=0, dma_select=0, dma_data=0, done=0, done_count=0, err_zero=0, err_timeout=0, cmd_ready=1. The DMA is not reset by this block.
- FIFO:
  - Push when cmd_valid & cmd_ready; cmd_ready = !full (registered count, no bypass).
  - Push and pop in the same cycle is legal at any occupancy except full, where push is blocked.
- States: IDLE, PROG, WAIT_BUSY, WAIT_DONE, DONE.
- IDLE:
  - If FIFO non-empty: pop the head into the descriptor register.
  - If cols==0 or rows==0: set err_zero and stay IDLE; the entry is consumed and nothing is written to the DMA.
  - Otherwise: beat counter=0, go to PROG.
- PROG: 6 consecutive beats with registered outputs dma_write=1, dma_select/dma_data:
  - beat0 sel0=cols
  - beat1 sel1=rows
  - beat2 sel6=stride
  - beat3 sel2={0,set}
  - beat4 sel4=src
  - beat5 sel3=1 (start)
  - The start write is always last because the DMA computes its final address from the registers current at the start write.
  - The first beat is visible in the cycle after the pop edge. After beat5: dma_write=0, timeout counter=0, go to WAIT_BUSY.
- WAIT_BUSY:
  - dma_busy==1 -> WAIT_DONE.
  - Timeout counter reaching START_TIMEOUT with busy still low -> set err_timeout and go to IDLE. The descriptor is lost and done does not pulse.
- WAIT_DONE: on dma_busy==0 (busy falling edge) -> DONE.
  - Completion is taken only from busy falling. The DMA finished flag is level and never self-clears, so it is not used.
- DONE: done=1 for one cycle, done_count+1, -> IDLE.
- Back-to-back descriptors: the next PROG starts no earlier than one cycle after DONE; dma_write is never asserted while dma_busy==1.
- dma_write is low in every state except PROG.
- Reset mid-operation (any state): immediate return to reset values; a partially programmed DMA keeps its registers and the bench must not rely on them.
- done_count wraps from 2^DATAWIDTH-1 to 0 with no flag.

Test Plan:
- Single transfer: push cols=3, rows=2, stride=0, set=1, src=0x10. Required writes in order (0,3),(1,2),(6,0),(2,1),(4,0x10),(3,1) on 6 consecutive cycles. Model asserts busy 2 cycles after start for 8 cycles, then drops it -> done pulses 1 cycle after the fall, done_count=1, seq_busy=0 afterwards.
- FIFO full: hold the model busy and push 6 descriptors at DEPTH=4 -> the first is popped and the FIFO fills with 4. cmd_ready falls after the 5th accepted push; the 6th is held until DONE. All 6 later complete in order and done_count=6.
- Zero dimension: push cols=0, rows=5, then a valid descriptor -> err_zero=1, no dma_write for the first, and the second is programmed normally.
- Timeout: the model never asserts busy -> err_timeout set START_TIMEOUT+1 cycles after beat5, state IDLE, done_count unchanged, and the next descriptor still processes.
- Back-to-back: push 2 descriptors, src=0x00 and 0x40 -> the second sel0 write appears only after the first busy falls plus DONE. Check no dma_write overlaps busy.
- Reset mid-PROG: drive rst=0 at beat3 -> next cycle dma_write=0, cmd_ready=1, FIFO empty, all status outputs 0.

Source files
------------

// File: rtl/ast_dma_sequencer_if.sv
// Bundles the descriptor valid/ready channel and the DMA register-programming port.
// master = the sequencer (consumes descriptors, drives the DMA registers); slave = host/DMA side.
interface ast_dma_sequencer_if #(
  parameter int DATAWIDTH = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [DATAWIDTH-1:0] cmd_cols;
  logic [DATAWIDTH-1:0] cmd_rows;
  logic [DATAWIDTH-1:0] cmd_stride;
  logic [1:0]           cmd_set;
  logic [DATAWIDTH-1:0] cmd_src;

  logic                 dma_write;
  logic [2:0]           dma_select;
  logic [DATAWIDTH-1:0] dma_data;
  logic                 dma_busy;

  modport master (
    input  cmd_valid, cmd_cols, cmd_rows, cmd_stride, cmd_set, cmd_src,
    output cmd_ready,
    output dma_write, dma_select, dma_data,
    input  dma_busy
  );

  modport slave (
    output cmd_valid, cmd_cols, cmd_rows, cmd_stride, cmd_set, cmd_src,
    input  cmd_ready,
    input  dma_write, dma_select, dma_data,
    output dma_busy
  );
endinterface

// File: rtl/ast_dma_sequencer.sv
// Descriptor FIFO plus FSM that programs the AST DMA register file, starts it and
// tracks completion through the falling edge of dma_busy.
module ast_dma_sequencer #(
  parameter int DATAWIDTH     = 8,
  parameter int DEPTH         = 4,
  parameter int START_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  ast_dma_sequencer_if.master  bus,
  output logic                 seq_busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] done_count,
  output logic                 err_zero,
  output logic                 err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT + 1) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [2:0]    LAST_BEAT_DONE = 3'd6;

  localparam logic [2:0] SEL_COLS   = 3'd0;
  localparam logic [2:0] SEL_ROWS   = 3'd1;
  localparam logic [2:0] SEL_SET    = 3'd2;
  localparam logic [2:0] SEL_START  = 3'd3;
  localparam logic [2:0] SEL_SRC    = 3'd4;
  localparam logic [2:0] SEL_STRIDE = 3'd6;

  typedef struct packed {
    logic [DATAWIDTH-1:0] cols;
    logic [DATAWIDTH-1:0] rows;
    logic [DATAWIDTH-1:0] stride;
    logic [1:0]           set;
    logic [DATAWIDTH-1:0] src;
  } desc_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROG,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  // Start goes last: the DMA latches its final address from registers current at start.
  function automatic logic [DATAWIDTH+2:0] beat_word(input logic [2:0] idx, input desc_t d);
    logic [DATAWIDTH+2:0] w;
    case (idx)
      3'd0:    w = {SEL_COLS, d.cols};
      3'd1:    w = {SEL_ROWS, d.rows};
      3'd2:    w = {SEL_STRIDE, d.stride};
      3'd3:    w = {SEL_SET, DATAWIDTH'(d.set)};
      3'd4:    w = {SEL_SRC, d.src};
      default: w = {SEL_START, DATAWIDTH'(1)};
    endcase
    return w;
  endfunction

  desc_t                fifo_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          cnt_q;
  desc_t                in_desc, head;
  logic                 full, push, pop;

  state_t               state_q, state_d;
  desc_t                desc_q, desc_d;
  logic [2:0]           beat_q, beat_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 wr_q, wr_d;
  logic [2:0]           sel_q, sel_d;
  logic [DATAWIDTH-1:0] dat_q, dat_d;
  logic                 done_q, done_d;
  logic [DATAWIDTH-1:0] done_count_q, done_count_d;
  logic                 err_zero_q, err_zero_d;
  logic                 err_timeout_q, err_timeout_d;

  assign in_desc = '{cols:   bus.cmd_cols,
                     rows:   bus.cmd_rows,
                     stride: bus.cmd_stride,
                     set:    bus.cmd_set,
                     src:    bus.cmd_src};

  // Ready comes from the registered count only; a full FIFO never bypasses a pop.
  assign full          = (cnt_q == FULL_CNT);
  assign bus.cmd_ready = !full;
  assign push          = bus.cmd_valid && !full;
  assign head          = fifo_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= in_desc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    desc_d        = desc_q;
    beat_d        = beat_q;
    tmo_d         = tmo_q;
    wr_d          = 1'b0;
    sel_d         = '0;
    dat_d         = '0;
    done_d        = 1'b0;
    done_count_d  = done_count_q;
    err_zero_d    = err_zero_q;
    err_timeout_d = err_timeout_q;
    pop           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          pop    = 1'b1;
          desc_d = head;
          if ((head.cols == '0) || (head.rows == '0)) begin
            err_zero_d = 1'b1;
          end else begin
            wr_d           = 1'b1;
            {sel_d, dat_d} = beat_word(3'd0, head);
            beat_d         = 3'd1;
            state_d        = S_PROG;
          end
        end
      end
      // beat_q holds the index of the beat to present next cycle.
      S_PROG: begin
        if (beat_q == LAST_BEAT_DONE) begin
          tmo_d   = '0;
          state_d = S_WAIT_BUSY;
        end else begin
          wr_d           = 1'b1;
          {sel_d, dat_d} = beat_word(beat_q, desc_q);
          beat_d         = beat_q + 3'd1;
        end
      end
      S_WAIT_BUSY: begin
        if (bus.dma_busy) begin
          state_d = S_WAIT_DONE;
        end else if (tmo_q == TMO_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      // The DMA finished flag is a level that never clears, so only busy falling counts.
      S_WAIT_DONE: begin
        if (!bus.dma_busy) begin
          done_d       = 1'b1;
          done_count_d = done_count_q + DATAWIDTH'(1);
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      beat_q        <= '0;
      tmo_q         <= '0;
      wr_q          <= 1'b0;
      sel_q         <= '0;
      dat_q         <= '0;
      done_q        <= 1'b0;
      done_count_q  <= '0;
      err_zero_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      tmo_q         <= tmo_d;
      wr_q          <= wr_d;
      sel_q         <= sel_d;
      dat_q         <= dat_d;
      done_q        <= done_d;
      done_count_q  <= done_count_d;
      err_zero_q    <= err_zero_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  always_ff @(posedge clk) begin
    desc_q <= desc_d;
  end

  assign bus.dma_write  = wr_q;
  assign bus.dma_select = sel_q;
  assign bus.dma_data   = dat_q;

  assign seq_busy    = (state_q != S_IDLE) || (cnt_q != '0);
  assign done        = done_q;
  assign done_count  = done_count_q;
  assign err_zero    = err_zero_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_ast_dma_sequencer.sv
// Directed bench for ast_dma_sequencer with a transaction-level model of the expected
// register-write stream, a simple DMA busy responder, and per-cycle output comparison.
module tb_ast_dma_sequencer;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          seq_busy, done, err_zero, err_timeout;
  logic [DW-1:0] done_count;

  ast_dma_sequencer_if #(.DATAWIDTH(DW)) bus ();

  ast_dma_sequencer #(
    .DATAWIDTH    (DW),
    .DEPTH        (DEPTH),
    .START_TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .seq_busy   (seq_busy),
    .done       (done),
    .done_count (done_count),
    .err_zero   (err_zero),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Model state: expected {select,data} stream and DMA responder schedule.
  int            cyc = 0;
  logic [10:0]   exp_q[$];
  logic [10:0]   w;
  int            prog_idx = 0;
  bit            armed = 0;
  int            busy_len = 8;
  bit            bsched = 0;
  int            busy_start = 0, busy_end = 0;
  int            done_due = -1;
  bit            inflight = 0;
  logic [DW-1:0] exp_cnt = '0;
  bit            zero_seen = 0;
  bit            to_armed = 0;
  int            to_deadline = 0;
  bit            exp_to = 0;
  int            beat0_cyc = 0, beat5_cyc = 0, done_cyc = 0, to_cyc = 0;

  initial begin
    bus.dma_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bsched) begin
        bus.dma_busy = (cyc >= busy_start) && (cyc < busy_end);
        if (cyc == busy_end) begin
          done_due = cyc + 1;
          bsched   = 0;
        end
      end else begin
        bus.dma_busy = 1'b0;
      end

      if (armed) begin
        if (bus.dma_write) begin
          check("wr_pending", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check("wr_sel_data", int'({bus.dma_select, bus.dma_data}), int'(w));
            if (prog_idx == 0) begin
              beat0_cyc = cyc;
              check("start_after_done", int'(inflight), 0);
            end
            if (prog_idx == 5) begin
              beat5_cyc = cyc;
              if (busy_len > 0) begin
                bsched     = 1;
                busy_start = cyc + 2;
                busy_end   = cyc + 2 + busy_len;
                inflight   = 1;
              end else begin
                to_armed    = 1;
                to_deadline = cyc + TMO + 1;
              end
            end
            prog_idx = (prog_idx + 1) % 6;
          end
          check("wr_vs_busy", int'(bus.dma_busy), 0);
        end else if (prog_idx != 0) begin
          check("wr_contiguous", int'(bus.dma_write), 1);
          prog_idx = 0;
        end

        if (cyc == done_due) begin
          exp_cnt  = exp_cnt + DW'(1);
          done_cyc = cyc;
          inflight = 0;
        end
        check("done", int'(done), int'(cyc == done_due));
        check("done_count", int'(done_count), int'(exp_cnt));

        if (to_armed && cyc == to_deadline) begin
          exp_to   = 1;
          to_cyc   = cyc;
          to_armed = 0;
        end
        check("err_timeout", int'(err_timeout), int'(exp_to));
        if (!zero_seen) check("err_zero_clear", int'(err_zero), 0);
        if (exp_q.size() != 0 || bus.dma_busy || inflight) check("seq_busy_active", int'(seq_busy), 1);
      end

      if (rst && bus.cmd_valid && bus.cmd_ready) begin
        if (bus.cmd_cols == '0 || bus.cmd_rows == '0) begin
          zero_seen = 1;
        end else begin
          exp_q.push_back({3'd0, bus.cmd_cols});
          exp_q.push_back({3'd1, bus.cmd_rows});
          exp_q.push_back({3'd6, bus.cmd_stride});
          exp_q.push_back({3'd2, 6'd0, bus.cmd_set});
          exp_q.push_back({3'd4, bus.cmd_src});
          exp_q.push_back({3'd3, 8'd1});
        end
      end

      if (!rst) begin
        exp_q.delete();
        prog_idx     = 0;
        bsched       = 0;
        bus.dma_busy = 1'b0;
        done_due     = -1;
        inflight     = 0;
        exp_cnt      = '0;
        zero_seen    = 0;
        to_armed     = 0;
        exp_to       = 0;
        armed        = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] c, input logic [7:0] r, input logic [7:0] s,
                      input logic [1:0] st, input logic [7:0] a);
    bit ok;
    ok             = 0;
    bus.cmd_cols   = c;
    bus.cmd_rows   = r;
    bus.cmd_stride = s;
    bus.cmd_set    = st;
    bus.cmd_src    = a;
    bus.cmd_valid  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        ok = 1;
        break;
      end
    end
    tick();
    bus.cmd_valid = 1'b0;
    if (!ok) check("push_accepted", int'(ok), 1);
  endtask

  task automatic wait_count(input logic [7:0] target, input string name);
    for (int i = 0; i < 1500; i++) begin
      if (done_count == target) break;
      tick();
    end
    check(name, int'(done_count), int'(target));
  endtask

  int d1;

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_cols   = '0;
    bus.cmd_rows   = '0;
    bus.cmd_stride = '0;
    bus.cmd_set    = '0;
    bus.cmd_src    = '0;
    rst = 1'b0;
    repeat (3) tick();

    check("rst_cmd_ready", int'(bus.cmd_ready), 1);
    check("rst_seq_busy", int'(seq_busy), 0);
    check("rst_dma_write", int'(bus.dma_write), 0);
    check("rst_dma_select", int'(bus.dma_select), 0);
    check("rst_dma_data", int'(bus.dma_data), 0);
    check("rst_done", int'(done), 0);
    check("rst_done_count", int'(done_count), 0);
    check("rst_err_zero", int'(err_zero), 0);
    check("rst_err_timeout", int'(err_timeout), 0);
    rst = 1'b1;
    tick();

    // Single transfer
    busy_len = 8;
    push(8'd3, 8'd2, 8'd0, 2'd1, 8'h10);
    wait_count(8'd1, "t1_done_reached");
    tick();
    check("t1_done_latency", done_cyc - beat0_cyc, 16);
    check("t1_count", int'(done_count), 1);
    check("t1_seq_busy_idle", int'(seq_busy), 0);

    // FIFO full with the DMA held busy
    rst = 1'b0;
    tick();
    rst = 1'b1;
    busy_len = 40;
    for (int i = 0; i < 5; i++) push(8'(i + 1), 8'd2, 8'd1, 2'(i), 8'(8'h20 + i));
    check("t2_ready_low_when_full", int'(bus.cmd_ready), 0);
    for (int i = 0; i < 100; i++) begin
      if (inflight) break;
      tick();
    end
    busy_len = 8;
    push(8'd7, 8'd7, 8'd0, 2'd3, 8'h2f);
    wait_count(8'd6, "t2_six_done");
    check("t2_ready_after_drain", int'(bus.cmd_ready), 1);

    // Zero-dimension descriptor followed by a valid one
    push(8'd0, 8'd5, 8'd0, 2'd0, 8'h30);
    push(8'd4, 8'd1, 8'd2, 2'd3, 8'h33);
    wait_count(8'd7, "t3_done_reached");
    check("t3_err_zero", int'(err_zero), 1);
    check("t3_err_timeout", int'(err_timeout), 0);

    // Start timeout: the DMA never raises busy
    busy_len = 0;
    push(8'd2, 8'd2, 8'd1, 2'd0, 8'h50);
    for (int i = 0; i < 200; i++) begin
      if (err_timeout) break;
      tick();
    end
    check("t4_timeout_reached", int'(err_timeout), 1);
    tick();
    check("t4_timeout_latency", to_cyc - beat5_cyc, TMO + 1);
    check("t4_count_unchanged", int'(done_count), 7);
    check("t4_idle", int'(seq_busy), 0);
    busy_len = 8;
    push(8'd1, 8'd1, 8'd0, 2'd2, 8'h60);
    wait_count(8'd8, "t4_next_done");

    // Back-to-back descriptors
    push(8'd1, 8'd2, 8'd0, 2'd0, 8'h00);
    push(8'd1, 8'd2, 8'd0, 2'd0, 8'h40);
    wait_count(8'd9, "t5_first_done");
    tick();
    d1 = done_cyc;
    wait_count(8'd10, "t5_second_done");
    tick();
    check("t5_second_beat0_gap", beat0_cyc - d1, 2);

    // Reset in the middle of programming
    push(8'd5, 8'd6, 8'd7, 2'd3, 8'h77);
    push(8'd5, 8'd6, 8'd7, 2'd3, 8'h78);
    for (int i = 0; i < 50; i++) begin
      if (bus.dma_write && bus.dma_select == 3'd2) break;
      tick();
    end
    check("t6_beat3_seen", int'(bus.dma_write && bus.dma_select == 3'd2), 1);
    rst = 1'b0;
    tick();
    check("t6_dma_write", int'(bus.dma_write), 0);
    check("t6_cmd_ready", int'(bus.cmd_ready), 1);
    check("t6_fifo_empty", int'(seq_busy), 0);
    check("t6_done", int'(done), 0);
    check("t6_done_count", int'(done_count), 0);
    check("t6_err_zero", int'(err_zero), 0);
    check("t6_err_timeout", int'(err_timeout), 0);
    rst = 1'b1;
    push(8'd2, 8'd3, 8'd0, 2'd1, 8'h11);
    wait_count(8'd1, "t6_after_reset_done");
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
